// File: rtl/ma_pkg.sv
// Shared types and helper functions for the streaming moving-average filter.
package ma_pkg;

  // Filter sequencing: accept a sample, fold it into the running sum, present the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    OUTPUT = 2'd2
  } ma_state_e;

  // Running-sum width: a full window of maximum-value samples cannot overflow it.
  function automatic int sum_width(input int data_w, input int max_pow);
    return data_w + max_pow;
  endfunction

  // Depth of the sample history buffer.
  function automatic int buf_depth(input int max_pow);
    return 1 << max_pow;
  endfunction

  // Requested window exponents beyond the buffer depth fall back to the largest window.
  function automatic int clamp_pow(input int req, input int max_pow);
    return (req > max_pow) ? max_pow : req;
  endfunction

endpackage

// File: rtl/ma_sample_buf.sv
// Sample history: one write port and one combinational read port.
module ma_sample_buf
  import ma_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_POW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [MAX_POW-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [MAX_POW-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = buf_depth(MAX_POW);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the incoming sample; the read below sees the pre-write contents in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/moving_average_stream.sv
// Streaming moving-average filter with a run-time window of 2^p samples,
// a running sum updated per sample, and valid/ready handshakes on both sides.
module moving_average_stream
  import ma_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_POW = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic [$clog2(MAX_POW+1)-1:0] win_pow_i,
  input  logic                         round_i,
  input  logic [DATA_W-1:0]            in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [DATA_W-1:0]            out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         filled_o
);

  localparam int SUM_W = sum_width(DATA_W, MAX_POW);
  localparam int PW    = $clog2(MAX_POW + 1);
  localparam int CW    = MAX_POW + 1;
  localparam int AW    = MAX_POW;

  ma_state_e         state_q, state_d;
  logic [SUM_W-1:0]  sum_q, sum_d, sum_upd;
  logic [CW-1:0]     count_q, count_d, win;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_addr;
  logic [PW-1:0]     p_q, p_d, p_clamped;
  logic [DATA_W-1:0] new_q, new_d, old_q, old_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, rd_data, avg;
  logic              rnd_q, rnd_d, buf_we;
  logic [SUM_W:0]    rnd_add, rounded;

  // Window size and the slot holding the sample that is about to leave the window.
  assign win       = CW'(1) << p_q;
  assign rd_addr   = wr_ptr_q - win[AW-1:0];
  assign p_clamped = PW'(clamp_pow(int'(win_pow_i), MAX_POW));

  ma_sample_buf #(
    .DATA_W (DATA_W),
    .MAX_POW(MAX_POW)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (buf_we),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(in_data_i),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  // Running sum after folding in the captured new/old pair; never goes negative.
  assign sum_upd = sum_q + SUM_W'(new_q) - SUM_W'(old_q);

  // Half-LSB rounding offset, applied only when rounding is requested and the window exceeds one sample.
  always_comb begin
    rnd_add = '0;
    if (rnd_q && (p_q != '0)) begin
      rnd_add = (SUM_W + 1)'(1) << (p_q - PW'(1));
    end
  end

  assign rounded = {1'b0, sum_upd} + rnd_add;
  assign avg     = DATA_W'(rounded >> p_q);

  // Next-state logic for the sequencer, running sum, pointers and result register.
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    p_d        = p_q;
    new_d      = new_q;
    old_d      = old_q;
    rnd_d      = rnd_q;
    out_data_d = out_data_q;
    buf_we     = 1'b0;
    if (clear_i) begin
      state_d    = IDLE;
      sum_d      = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      p_d        = p_clamped;
      out_data_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            buf_we  = 1'b1;
            new_d   = in_data_i;
            old_d   = (count_q >= win) ? rd_data : '0;
            rnd_d   = round_i;
            state_d = UPDATE;
          end
        end
        UPDATE: begin
          sum_d      = sum_upd;
          wr_ptr_d   = wr_ptr_q + AW'(1);
          count_d    = (count_q < win) ? count_q + CW'(1) : count_q;
          out_data_d = avg;
          state_d    = OUTPUT;
        end
        OUTPUT: begin
          if (out_ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset returns to an empty window of one sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sum_q      <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      p_q        <= '0;
      new_q      <= '0;
      old_q      <= '0;
      rnd_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      p_q        <= p_d;
      new_q      <= new_d;
      old_q      <= old_d;
      rnd_q      <= rnd_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready_o  = rst_n && (state_q == IDLE) && !clear_i;
  assign out_valid_o = (state_q == OUTPUT);
  assign out_data_o  = out_data_q;
  assign filled_o    = (count_q == win);

endmodule

// File: tb/tb_moving_average_stream.sv
// Directed self-checking bench for the moving-average filter.
module tb_moving_average_stream;

  logic       clk;
  logic       rst_n;
  logic       clear_i;
  logic [2:0] win_pow_i;
  logic       round_i;
  logic [7:0] in_data_i;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       filled_o;

  int checks;
  int errors;

  moving_average_stream #(
    .DATA_W (8),
    .MAX_POW(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear_i),
    .win_pow_i  (win_pow_i),
    .round_i    (round_i),
    .in_data_i  (in_data_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .filled_o   (filled_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and report it when the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Push one sample through a full handshake with the consumer always ready, then check the result.
  task automatic applyStimulus(input logic [7:0] data, input logic rnd, input logic [7:0] expected, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_inready"}, 32'(in_ready_o), 32'd1);
    in_data_i   = data;
    round_i     = rnd;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    n = 0;
    while (!out_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    checkOutput(tag, 32'(out_data_o), 32'(expected));
  endtask

  // Synchronous flush that also loads a new window exponent.
  task automatic applyClear(input logic [2:0] pow);
    @(negedge clk);
    clear_i   = 1'b1;
    win_pow_i = pow;
    @(posedge clk);
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    clear_i     = 1'b0;
    win_pow_i   = 3'd0;
    round_i     = 1'b0;
    in_data_i   = 8'd0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_inready", 32'(in_ready_o), 32'd0);
    checkOutput("rst_outvalid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_outdata", 32'(out_data_o), 32'd0);
    checkOutput("rst_filled", 32'(filled_o), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_inready", 32'(in_ready_o), 32'd1);

    // Window 8, truncate, constant 8: ramp 1..8 then steady 8
    applyClear(3'd3);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(8'd8, 1'b0, 8'((i <= 8) ? i : 8), $sformatf("t1_s%0d", i));
      checkOutput($sformatf("t1_filled%0d", i), 32'(filled_o), 32'((i >= 8) ? 1 : 0));
    end

    // Window 4 with rounding, then without
    applyClear(3'd2);
    applyStimulus(8'd1, 1'b1, 8'd0, "t2_r1");
    applyStimulus(8'd2, 1'b1, 8'd1, "t2_r2");
    applyStimulus(8'd2, 1'b1, 8'd1, "t2_r3");
    applyStimulus(8'd2, 1'b1, 8'd2, "t2_r4");
    applyClear(3'd2);
    applyStimulus(8'd1, 1'b0, 8'd0, "t2_t1");
    applyStimulus(8'd2, 1'b0, 8'd0, "t2_t2");
    applyStimulus(8'd2, 1'b0, 8'd1, "t2_t3");
    applyStimulus(8'd2, 1'b0, 8'd1, "t2_t4");

    // Oversized exponent clamps to window 16: (16+8)>>4 = 1
    applyClear(3'd7);
    applyStimulus(8'd16, 1'b1, 8'd1, "clamp");

    // Window 16, full-scale samples across a pointer wrap
    applyClear(3'd4);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(8'd255, 1'b0, 8'((i >= 16) ? 255 : (255 * i) / 16), $sformatf("t3_s%0d", i));
    end
    checkOutput("t3_filled", 32'(filled_o), 32'd1);

    // Backpressure, window 2: sample 10 -> 5 held, then 20 -> 15
    applyClear(3'd1);
    @(negedge clk);
    in_data_i   = 8'd10;
    round_i     = 1'b0;
    in_valid_i  = 1'b1;
    out_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data_i = 8'd20;
    checkOutput("t4_upd_valid", 32'(out_valid_o), 32'd0);
    checkOutput("t4_upd_inready", 32'(in_ready_o), 32'd0);
    @(negedge clk);
    checkOutput("t4_valid", 32'(out_valid_o), 32'd1);
    checkOutput("t4_data", 32'(out_data_o), 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t4_hold_data%0d", i), 32'(out_data_o), 32'd5);
      checkOutput($sformatf("t4_hold_valid%0d", i), 32'(out_valid_o), 32'd1);
      checkOutput($sformatf("t4_hold_inready%0d", i), 32'(in_ready_o), 32'd0);
    end
    out_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t4_idle_inready", 32'(in_ready_o), 32'd1);
    checkOutput("t4_idle_valid", 32'(out_valid_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("t4_second_valid", 32'(out_valid_o), 32'd1);
    checkOutput("t4_second_data", 32'(out_data_o), 32'd15);
    checkOutput("t4_second_filled", 32'(filled_o), 32'd1);
    out_ready_i = 1'b0;

    // Clear with a pending output and a simultaneous sample
    @(negedge clk);
    clear_i    = 1'b1;
    win_pow_i  = 3'd1;
    in_data_i  = 8'd99;
    in_valid_i = 1'b1;
    #1;
    checkOutput("t5_clear_inready", 32'(in_ready_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    clear_i    = 1'b0;
    in_valid_i = 1'b0;
    checkOutput("t5_valid", 32'(out_valid_o), 32'd0);
    checkOutput("t5_filled", 32'(filled_o), 32'd0);
    applyStimulus(8'd40, 1'b0, 8'd20, "t5_first");
    applyStimulus(8'd40, 1'b0, 8'd40, "t5_second");
    checkOutput("t5_second_filled", 32'(filled_o), 32'd1);

    // Asynchronous reset in the middle of an update
    @(negedge clk);
    in_data_i  = 8'd9;
    in_valid_i = 1'b1;
    @(posedge clk);
    #2;
    rst_n      = 1'b0;
    in_valid_i = 1'b0;
    #1;
    checkOutput("t6_rst_data", 32'(out_data_o), 32'd0);
    checkOutput("t6_rst_valid", 32'(out_valid_o), 32'd0);
    checkOutput("t6_rst_inready", 32'(in_ready_o), 32'd0);
    checkOutput("t6_rst_filled", 32'(filled_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("t6_rel_inready", 32'(in_ready_o), 32'd1);
    applyStimulus(8'd6, 1'b0, 8'd6, "t6_after");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
